// File: rtl/seq_array_multiplier.sv
// Multi-cycle shift-and-add multiplier with signed/unsigned mode and valid/ready handshakes.
// One WIDTH-bit adder is reused across WIDTH cycles; one multiplication is in flight at a time.
module seq_array_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     product_q, product_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     acc_step;

  // Datapath for one step: conditional add into the upper half, then shift right.
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};
    acc_step = PW'({sum, acc_q[WIDTH-1:0]} >> 1);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
          mcand_d  = (signed_mode && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
          mplier_d = (signed_mode && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = neg_q ? (PW'(0) - acc_step) : acc_step;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier (WIDTH=8) against an arithmetic reference model.
module tb_seq_array_multiplier;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  seq_array_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer multiplication, truncated to the product width.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
    int ix, iy;
    if (sm) begin
      ix = int'($signed(x));
      iy = int'($signed(y));
    end else begin
      ix = int'({24'd0, x});
      iy = int'({24'd0, y});
    end
    return (2*W)'(ix * iy);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, counting edges; busy must stay high while waiting.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      lat++;
    end
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // One complete transaction; operands are scrambled after the accept edge.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sm);
    int lat;
    logic [2*W-1:0] exp_p;
    exp_p = ref_mul(x, y, sm);
    check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    a = x; b = y; signed_mode = sm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    check({tag, "_in_ready_calc"}, 32'(in_ready), 32'd0);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_product_held"}, 32'(product), 32'(exp_p));
  endtask

  logic [W-1:0]   qa [3];
  logic [W-1:0]   qb [3];
  logic           qs [3];
  logic [2*W-1:0] bp_exp;
  int             lat, idx, nres, cyc, last;
  logic           took;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed cases from the plan.
    run_op("u13x11", 8'h0D, 8'h0B, 1'b0);
    check("u13x11_const", 32'(ref_mul(8'h0D, 8'h0B, 1'b0)), 32'h008F);
    run_op("u255x255", 8'hFF, 8'hFF, 1'b0);
    check("u255x255_val", 32'(product), 32'hFE01);
    run_op("u0x200", 8'h00, 8'd200, 1'b0);
    check("u0x200_val", 32'(product), 32'h0000);
    run_op("s_m3x5", 8'hFD, 8'h05, 1'b1);
    check("s_m3x5_val", 32'(product), 32'hFFF1);
    run_op("s_m128xm128", 8'h80, 8'h80, 1'b1);
    check("s_m128xm128_val", 32'(product), 32'h4000);
    run_op("s_m128x127", 8'h80, 8'h7F, 1'b1);
    check("s_m128x127_val", 32'(product), 32'hC080);

    // Randomized operands in both modes.
    for (int i = 0; i < 16; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    // Backpressure with ignored in_valid pulses during CALC and DONE.
    bp_exp = ref_mul(8'h5A, 8'h3C, 1'b0);
    a = 8'h5A; b = 8'h3C; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'hFF; signed_mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("bp", lat);
    check("bp_latency", 32'(lat + 3), 32'(W));
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = W'($urandom); b = W'($urandom);
      tick();
      check("bp_out_valid_hold", 32'(out_valid), 32'd1);
      check("bp_product_hold", 32'(product), 32'(bp_exp));
      check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_product", 32'(product), 32'(bp_exp));

    // Back-to-back with in_valid and out_ready held high.
    qa[0] = 8'h0D; qb[0] = 8'h0B; qs[0] = 1'b0;
    qa[1] = 8'hFD; qb[1] = 8'h05; qs[1] = 1'b1;
    qa[2] = W'($urandom); qb[2] = W'($urandom); qs[2] = 1'($urandom);
    idx = 0; nres = 0; cyc = 0; last = 0;
    a = qa[0]; b = qb[0]; signed_mode = qs[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && nres < 3; c++) begin
      took = in_ready & in_valid;
      tick();
      cyc++;
      if (took) begin
        idx++;
        if (idx < 3) begin
          a = qa[idx]; b = qb[idx]; signed_mode = qs[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check("b2b_product", 32'(product), 32'(ref_mul(qa[nres], qb[nres], qs[nres])));
        if (nres > 0) check("b2b_spacing", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        nres++;
      end
    end
    check("b2b_count", 32'(nres), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    // Reset 4 edges into CALC discards the result.
    a = 8'h12; b = 8'h34; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mid_no_out_valid", 32'(out_valid), 32'd0);
    end
    run_op("post_rst_7x9", 8'd7, 8'd9, 1'b0);
    check("post_rst_7x9_val", 32'(product), 32'h003F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
